// File: rtl/lut_func_unit.sv
// lut_func_unit: registered N-input LUT with serial table reload; optional minterm sweep under LUT_FUNC_SWEEP_EN
module lut_func_unit #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] INIT_TABLE = 16'h1731
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_vec,
  output logic            f_out,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic            load_bit,
  output logic            load_done,
  output logic            busy,
  input  logic            sweep_start,
  output logic            sweep_done,
  output logic [N_IN:0]   ones_count
);
`ifdef LUT_FUNC_SWEEP_EN
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;
`else
  typedef enum logic {IDLE, LOAD} state_t;
`endif
  state_t state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [(1<<N_IN)-1:0] active, shadow, shadow_wr;
  logic last, wr, sweep_go, in_sweep;
  assign last = &idx;
  assign wr = state == LOAD && !load_start && load_valid;
  assign busy = state != IDLE;
`ifdef LUT_FUNC_SWEEP_EN
  assign sweep_go = state == IDLE && !load_start && sweep_start;
  assign in_sweep = state == SWEEP;
`else
  logic sweep_unused;
  assign sweep_unused = sweep_start;
  assign sweep_go = 1'b0;
  assign in_sweep = 1'b0;
  assign sweep_done = 1'b0;
  assign ones_count = '0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: load beats sweep in IDLE; starts are ignored while sweeping
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef LUT_FUNC_SWEEP_EN
      IDLE:    state_nxt = load_start ? LOAD : sweep_start ? SWEEP : IDLE;
      SWEEP:   state_nxt = last ? IDLE : SWEEP;
`else
      IDLE:    state_nxt = load_start ? LOAD : IDLE;
`endif
      LOAD:    state_nxt = wr && last ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end
  // shadow table with the incoming serial bit merged at the current index
  always_comb begin
    shadow_wr = shadow;
    shadow_wr[idx] = load_bit;
  end
  // lookup, shadow fill, atomic commit on the final bit, shared load/sweep index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      active <= INIT_TABLE;
      shadow <= INIT_TABLE;
      f_out <= 1'b0;
      load_done <= 1'b0;
    end else begin
      f_out <= active[in_vec];
      load_done <= wr && last;
      if (wr) shadow <= shadow_wr;
      if (wr && last) active <= shadow_wr;
      if ((load_start && !in_sweep) || sweep_go) idx <= '0;
      else if (wr || in_sweep) idx <= idx + N_IN'(1);
    end
`ifdef LUT_FUNC_SWEEP_EN
  logic [N_IN:0] cnt, cnt_nxt;
  assign cnt_nxt = cnt + (N_IN+1)'(active[idx]);
  // population count of the active table, published once the last minterm is seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ones_count <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= in_sweep && last;
      if (sweep_go) cnt <= '0;
      else if (in_sweep) cnt <= cnt_nxt;
      if (in_sweep && last) ones_count <= cnt_nxt;
    end
`endif
endmodule

// File: tb/tb_lut_func_unit.sv
// tb_lut_func_unit: directed table-driven bench for lut_func_unit (N_IN=4)
module tb_lut_func_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] in_vec = '0;
  logic load_start = 1'b0, load_valid = 1'b0, load_bit = 1'b0, sweep_start = 1'b0;
  logic f_out, load_done, busy, sweep_done;
  logic [4:0] ones_count;
  int checks = 0, errors = 0, ld_cnt = 0, sd_cnt = 0, bad = 0, nb = 0;
  typedef struct {
    logic [3:0] in;
    logic       exp;
  } vec_t;
  vec_t v[16];

  always #5 clk = ~clk;

  lut_func_unit dut (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .f_out(f_out),
    .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
    .load_done(load_done), .busy(busy), .sweep_start(sweep_start),
    .sweep_done(sweep_done), .ones_count(ones_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    if (load_done) ld_cnt++;
    if (sweep_done) sd_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_table(input string name, input logic [15:0] t);
    for (int i = 0; i < 16; i++) begin
      in_vec = 4'(i);
      tick;
      check(name, 32'(f_out), 32'(t[i]));
    end
  endtask

  task automatic load_word(input logic [15:0] w, input bit gaps, input logic exp_f, output int nbad);
    nbad = 0;
    load_start = 1'b1;
    tick;
    if (f_out !== exp_f) nbad++;
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps && i % 3 == 1) begin
        load_valid = 1'b0;
        load_bit = ~w[i];
        tick;
        if (f_out !== exp_f) nbad++;
      end
      load_valid = 1'b1;
      load_bit = w[i];
      tick;
      if (f_out !== exp_f) nbad++;
    end
    load_valid = 1'b0;
  endtask

`ifdef LUT_FUNC_SWEEP_EN
  task automatic run_sweep(output int nbusy);
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !sweep_done; i++) begin
      if (busy) nbusy++;
      tick;
    end
  endtask
`endif

  initial begin
    v = '{'{4'd0, 1'b1}, '{4'd1, 1'b0}, '{4'd2, 1'b0}, '{4'd3, 1'b0},
          '{4'd4, 1'b1}, '{4'd5, 1'b1}, '{4'd6, 1'b0}, '{4'd7, 1'b0},
          '{4'd8, 1'b1}, '{4'd9, 1'b1}, '{4'd10, 1'b1}, '{4'd11, 1'b0},
          '{4'd12, 1'b1}, '{4'd13, 1'b0}, '{4'd14, 1'b0}, '{4'd15, 1'b0}};
    tick;
    tick;
    check("rst_f_out", 32'(f_out), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    check("rst_ones_count", 32'(ones_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vec = v[i].in;
      tick;
      check("init_table", 32'(f_out), 32'(v[i].exp));
    end
`ifdef LUT_FUNC_SWEEP_EN
    run_sweep(nb);
    check("sweep_busy_cycles", nb, 16);
    check("sweep_done_pulse", 32'(sweep_done), 1);
    check("sweep_ones_1731", 32'(ones_count), 7);
    tick;
    check("sweep_done_one_cycle", 32'(sweep_done), 0);
    check("ones_count_hold", 32'(ones_count), 7);
`else
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    check("sweep_ignored_busy", 32'(busy), 0);
    sd_cnt = 0;
    repeat (20) tick;
    check("sweep_done_tied", sd_cnt, 0);
    check("ones_count_tied", 32'(ones_count), 0);
`endif
    in_vec = 4'd4;
    tick;
    ld_cnt = 0;
    load_word(16'h8001, 1'b1, 1'b1, bad);
    check("old_table_during_load", bad, 0);
    check("load_done_at_commit", 32'(load_done), 1);
    check("busy_after_commit", 32'(busy), 0);
    tick;
    check("load_done_one_cycle", 32'(load_done), 0);
    check("new_table_in4", 32'(f_out), 0);
    check("load_done_count", ld_cnt, 1);
    check_table("table_8001", 16'h8001);
    in_vec = 4'd4;
    tick;
    ld_cnt = 0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_bit = 1'b0;
    repeat (9) tick;
    load_valid = 1'b0;
    check("partial_no_done", ld_cnt, 0);
    check("partial_busy", 32'(busy), 1);
    load_word(16'hFFFF, 1'b0, 1'b0, bad);
    check("restart_old_table", bad, 0);
    check("restart_done_count", ld_cnt, 1);
    check_table("table_ffff", 16'hFFFF);
`ifdef LUT_FUNC_SWEEP_EN
    run_sweep(nb);
    check("sweep_all_ones", 32'(ones_count), 16);
    sd_cnt = 0;
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #2;
    check("midsweep_rst_ones", 32'(ones_count), 0);
    check("midsweep_rst_busy", 32'(busy), 0);
    tick;
    rst_n = 1'b1;
    repeat (20) tick;
    check("midsweep_no_done", sd_cnt, 0);
    check_table("midsweep_rst_table", 16'h1731);
`endif
    load_word(16'hF0F0, 1'b0, f_out, bad);
    check_table("table_f0f0", 16'hF0F0);
    ld_cnt = 0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_bit = 1'b1;
    repeat (5) tick;
    rst_n = 1'b0;
    #2;
    check("midload_rst_busy", 32'(busy), 0);
    check("midload_rst_f_out", 32'(f_out), 0);
    load_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    check("midload_no_done", ld_cnt, 0);
    check_table("midload_rst_table", 16'h1731);
    ld_cnt = 0;
    sd_cnt = 0;
    load_start = 1'b1;
    sweep_start = 1'b1;
    tick;
    load_start = 1'b0;
    sweep_start = 1'b0;
    check("both_start_busy", 32'(busy), 1);
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_bit = i[2];
      tick;
    end
    load_valid = 1'b0;
    repeat (20) tick;
    check("both_start_load_done", ld_cnt, 1);
    check("both_start_no_sweep", sd_cnt, 0);
    check("both_start_idle", 32'(busy), 0);
    check_table("table_f0f0_again", 16'hF0F0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
